button_bank_monitor: RTL and testbench
======================================

BUTTON_BANK_MONITOR -- requirements
Module: button_bank_monitor

Interface
REQ-001 SHALL have parameter NUM_BUTTONS, default 4: number of independent button channels, range 1..16.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples needed to accept a level change, minimum 1.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16: cycles in the pressed state before a long-press is flagged, minimum 1.
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 buttonPress  input  NUM_BUTTONS  raw, asynchronous button levels; 1 = pressed.
REQ-007 buttonEdge  output  NUM_BUTTONS  one-cycle pulse per channel on each accepted press.
REQ-008 buttonHeld  output  NUM_BUTTONS  level per channel; high while a long-press is active.
REQ-009 buttonCode  output  clog2(NUM_BUTTONS), minimum 1  index of the reported press.
REQ-010 codeValid  output  1  one-cycle pulse qualifying buttonCode.

Function
REQ-011 Each channel SHALL pass buttonPress[i] through a two-flop synchroniser before any other logic.
REQ-012 Each channel SHALL run an FSM with four states:
- IDLE: stable released.
- DEB_PRESS: candidate press being counted.
- PRESSED: stable pressed.
- DEB_RELEASE: candidate release being counted.
REQ-013 IDLE SHALL move to DEB_PRESS when the synchronised input is 1; the debounce counter loads 1.
REQ-014 DEB_PRESS SHALL increment the counter while the input is 1, and SHALL move to PRESSED when the count reaches DEBOUNCE_CYCLES.
- Input 0 before that: return to IDLE, clear the counter, emit no edge.
REQ-015 buttonEdge[i] SHALL be high for exactly the one cycle after the IDLE/DEB_PRESS-to-PRESSED transition.
- Latency: DEBOUNCE_CYCLES+3 rising edges, counted from the first edge that samples buttonPress[i] high.
REQ-016 PRESSED SHALL count cycles in a hold counter that saturates at HOLD_CYCLES.
- buttonHeld[i] is asserted on the cycle the count reaches HOLD_CYCLES.
- buttonHeld[i] stays high until the channel returns to IDLE.
REQ-017 PRESSED SHALL move to DEB_RELEASE when the input is 0.
- DEB_RELEASE moves to IDLE after DEBOUNCE_CYCLES consecutive 0 samples.
- Any 1 sample returns to PRESSED. The hold counter and buttonHeld are kept; no new edge is emitted.
REQ-018 No channel SHALL emit a release pulse; a release only clears buttonHeld[i] and re-arms the channel.
REQ-019 When any buttonEdge bit is high, codeValid SHALL be high in the same cycle.
- buttonCode = index of the lowest-numbered asserted bit (fixed priority).
- Higher-index simultaneous edges appear only on buttonEdge and are not queued.
REQ-020 When codeValid is 0, buttonCode SHALL hold its last value.
REQ-021 Counter widths SHALL be clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES)+1); no counter SHALL wrap.
REQ-022 Channels SHALL be fully independent; activity on one SHALL NOT change another's timing.

Reset
REQ-023 While reset is high, every channel SHALL be IDLE with all counters and synchroniser flops at 0.
REQ-024 While reset is high, buttonEdge = 0, buttonHeld = 0, buttonCode = 0 and codeValid = 0, immediately and without waiting for a clock.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort with no pulse.
- After release, a button held high needs a full DEBOUNCE_CYCLES+3 edges before buttonEdge.
REQ-026 Reset deassertion SHALL NOT itself produce buttonEdge or codeValid.

Structure
REQ-027 The channel-state encoding (IDLE = 0, DEB_PRESS = 1, PRESSED = 2, DEB_RELEASE = 3) SHALL be defined as shared constants in a package, button_pkg.
REQ-028 The per-channel synchroniser, FSM and counters SHALL be in one sub-module, button_channel, instantiated NUM_BUTTONS times by a generate loop.
- The priority encoder for buttonCode and codeValid stays in the top level.

Verification (NUM_BUTTONS=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16)
REQ-029 Reset, then hold buttonPress=0001 -> single buttonEdge=0001 and codeValid=1 with buttonCode=0, on edge 7; no further pulses.
REQ-030 Bit 2 pulsed high for 3 cycles then low -> buttonEdge, codeValid and buttonHeld stay 0 throughout.
REQ-031 Bit 1 held 30 cycles -> buttonEdge pulse at edge 7; buttonHeld[1]=1 from 16 cycles after PRESSED entry; buttonHeld[1] clears DEBOUNCE_CYCLES+3 edges after the input falls.
REQ-032 buttonPress 0000->1010 simultaneously -> buttonEdge=1010 for one cycle, buttonCode=1, codeValid=1.
REQ-033 Pressed channel, release glitch of 2 cycles -> no second edge; buttonHeld unaffected.
REQ-034 Reset asserted in DEB_PRESS with input held high -> outputs 0 immediately; after deassertion, edge reappears only after a full 7 edges.

Source files
------------

// File: rtl/button_pkg.sv
// Shared channel-state encoding and width helpers for the button bank monitor.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } chan_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int code_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, debounce/hold FSM, registered press pulse and long-press level.
// Latency: press pulse DEBOUNCE_CYCLES+3 edges after the raw level is first sampled high.
// Backpressure: none; the input is sampled every cycle.
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic edge_pulse,
    output logic held
);

    localparam int CW = $clog2(max_int(DEBOUNCE_CYCLES, HOLD_CYCLES) + 1);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);

    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    chan_state_e   state_q, state_d;
    logic [CW-1:0] deb_q, deb_d, hold_q, hold_d;
    logic [CW-1:0] deb_inc;
    logic          edge_q, edge_d, held_q, held_d;

    assign deb_inc = deb_q + CW'(1);

    always_comb begin
        sync1_d = button_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE, DEB_PRESS: begin
                hold_d = '0;
                if (!sync2_q) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else if (deb_inc >= DEB_MAX) begin
                    state_d = PRESSED;
                    deb_d   = '0;
                end else begin
                    state_d = DEB_PRESS;
                    deb_d   = deb_inc;
                end
            end
            PRESSED: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + CW'(1);
                if (!sync2_q) begin
                    state_d = (deb_inc >= DEB_MAX) ? IDLE : DEB_RELEASE;
                    deb_d   = (deb_inc >= DEB_MAX) ? '0 : deb_inc;
                end
            end
            DEB_RELEASE: begin
                if (sync2_q) begin
                    state_d = PRESSED;
                    deb_d   = '0;
                end else if (deb_inc >= DEB_MAX) begin
                    state_d = IDLE;
                    deb_d   = '0;
                end else begin
                    deb_d   = deb_inc;
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = '0;
                hold_d  = '0;
            end
        endcase
        // Hold count is zero only on the first PRESSED cycle after a fresh press.
        edge_d = (state_q == PRESSED) && (hold_q == '0);
        held_d = (state_q != IDLE) && (hold_d == HOLD_MAX);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            edge_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            edge_q  <= edge_d;
            held_q  <= held_d;
        end
    end

    assign edge_pulse = edge_q;
    assign held       = held_q;

endmodule

// File: rtl/button_bank_monitor.sv
// Bank of independent debounced buttons with a fixed-priority code of the lowest pressed channel.
// Latency: code/valid in the same cycle as the press pulse.
// Backpressure: none; simultaneous higher-index presses are not queued.
module button_bank_monitor
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [NUM_BUTTONS-1:0]               buttonPress,
    output logic [NUM_BUTTONS-1:0]               buttonEdge,
    output logic [NUM_BUTTONS-1:0]               buttonHeld,
    output logic [code_width(NUM_BUTTONS)-1:0]   buttonCode,
    output logic                                 codeValid
);

    localparam int CODE_W = code_width(NUM_BUTTONS);

    logic [CODE_W-1:0] enc;
    logic [CODE_W-1:0] code_q, code_d;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .button_raw(buttonPress[g]),
            .edge_pulse(buttonEdge[g]),
            .held      (buttonHeld[g])
        );
    end

    always_comb begin
        enc = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (buttonEdge[i]) enc = CODE_W'(i);
        end
        code_d = codeValid ? enc : code_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) code_q <= '0;
        else       code_q <= code_d;
    end

    assign codeValid  = |buttonEdge;
    assign buttonCode = code_d;

endmodule

// File: tb/tb_button_bank_monitor.sv
// Random and directed stimulus against a run-length reference model of the button bank.
module tb_button_bank_monitor;

    localparam int NB   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] buttonPress = '0;
    logic [NB-1:0] buttonEdge, buttonHeld;
    logic [1:0]    buttonCode;
    logic          codeValid;

    button_bank_monitor #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .buttonPress(buttonPress),
        .buttonEdge(buttonEdge), .buttonHeld(buttonHeld),
        .buttonCode(buttonCode), .codeValid(codeValid)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted level per channel flips after DEB consecutive
    // disagreeing samples of the raw input seen two edges late.
    logic [NB-1:0] seen1, seen2;
    bit            acc[NB], held_m[NB], edge_pend[NB], rel_pend[NB];
    int            run[NB], hold[NB];
    logic [NB-1:0] exp_edge, exp_held;
    logic [1:0]    exp_code;

    function automatic void model_reset();
        seen1 = '0; seen2 = '0; exp_edge = '0; exp_held = '0; exp_code = '0;
        for (int i = 0; i < NB; i++) begin
            acc[i] = 0; held_m[i] = 0; edge_pend[i] = 0; rel_pend[i] = 0;
            run[i] = 0; hold[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [NB-1:0] in);
        bit s;
        exp_edge = '0;
        for (int i = 0; i < NB; i++) begin
            s = seen2[i];
            exp_edge[i] = edge_pend[i];
            edge_pend[i] = 0;
            if (rel_pend[i]) begin
                held_m[i] = 0; hold[i] = 0; rel_pend[i] = 0;
            end
            if (acc[i] && run[i] == 0 && hold[i] < HOLD) hold[i]++;
            if (hold[i] == HOLD) held_m[i] = 1;
            if (s != acc[i]) begin
                run[i]++;
                if (run[i] == DEB) begin
                    acc[i] = s;
                    run[i] = 0;
                    if (s) edge_pend[i] = 1;
                    else   rel_pend[i]  = 1;
                end
            end else begin
                run[i] = 0;
            end
            exp_held[i] = held_m[i];
        end
        for (int i = NB - 1; i >= 0; i--) if (exp_edge[i]) exp_code = 2'(i);
        seen2 = seen1;
        seen1 = in;
    endfunction

    // Scenario markers, counted in edges since the last mark().
    int            tick_no, edge_cycles, first_edge_at, held_on_at, held_off_at;
    logic [NB-1:0] first_edge_val;
    logic [1:0]    first_code;

    task automatic mark();
        tick_no = 0; edge_cycles = 0; first_edge_at = -1;
        held_on_at = -1; held_off_at = -1;
        first_edge_val = '0; first_code = '0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic tick(input logic [NB-1:0] in);
        buttonPress = in;
        @(posedge clock);
        if (!reset) model_step(in);
        #1;
        check_eq("edge", 32'(buttonEdge), 32'(exp_edge));
        check_eq("held", 32'(buttonHeld), 32'(exp_held));
        check_eq("valid", 32'(codeValid), 32'(|exp_edge));
        check_eq("code", 32'(buttonCode), 32'(exp_code));
        tick_no++;
        if (|buttonEdge) begin
            edge_cycles++;
            if (first_edge_at < 0) begin
                first_edge_at  = tick_no;
                first_edge_val = buttonEdge;
                first_code     = buttonCode;
            end
        end
        if (held_on_at < 0 && |buttonHeld) held_on_at = tick_no;
        if (held_off_at < 0 && buttonHeld == '0) held_off_at = tick_no;
        @(negedge clock);
    endtask

    task automatic do_reset(input logic [NB-1:0] in, input int n);
        buttonPress = in;
        reset = 1'b1;
        #1;
        check_eq("rst_edge", 32'(buttonEdge), 32'h0);
        check_eq("rst_held", 32'(buttonHeld), 32'h0);
        check_eq("rst_code", 32'(buttonCode), 32'h0);
        check_eq("rst_valid", 32'(codeValid), 32'h0);
        model_reset();
        repeat (n) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [NB-1:0] cur;

    initial begin
        model_reset();
        mark();
        @(negedge clock);

        // Single press on channel 0.
        do_reset('0, 2);
        mark();
        repeat (12) tick(4'b0001);
        check_eq("p0_latency", 32'(first_edge_at), 32'd7);
        check_eq("p0_pulses", 32'(edge_cycles), 32'd1);
        check_eq("p0_code", 32'(first_code), 32'd0);
        repeat (10) tick(4'b0000);

        // Short 3-cycle bounce on channel 2 is rejected.
        do_reset('0, 2);
        mark();
        repeat (3) tick(4'b0100);
        repeat (10) tick(4'b0000);
        check_eq("bounce_pulses", 32'(edge_cycles), 32'd0);
        check_eq("bounce_held", 32'(held_on_at), 32'hFFFF_FFFF);

        // Long press on channel 1, then release.
        do_reset('0, 2);
        mark();
        repeat (30) tick(4'b0010);
        check_eq("long_latency", 32'(first_edge_at), 32'd7);
        check_eq("long_held_on", 32'(held_on_at), 32'd22);
        mark();
        repeat (10) tick(4'b0000);
        check_eq("long_held_off", 32'(held_off_at), 32'd7);

        // Simultaneous press on channels 1 and 3.
        do_reset('0, 2);
        mark();
        repeat (10) tick(4'b1010);
        check_eq("dual_latency", 32'(first_edge_at), 32'd7);
        check_eq("dual_edge", 32'(first_edge_val), 32'hA);
        check_eq("dual_code", 32'(first_code), 32'd1);
        check_eq("dual_pulses", 32'(edge_cycles), 32'd1);

        // Two-cycle release glitch on a held channel.
        do_reset('0, 2);
        repeat (25) tick(4'b0001);
        mark();
        repeat (2) tick(4'b0000);
        repeat (10) tick(4'b0001);
        check_eq("glitch_pulses", 32'(edge_cycles), 32'd0);
        check_eq("glitch_held", 32'(held_off_at), 32'hFFFF_FFFF);

        // Reset in the middle of a press debounce with the input held high.
        do_reset('0, 2);
        repeat (4) tick(4'b1000);
        do_reset(4'b1000, 3);
        mark();
        repeat (10) tick(4'b1000);
        check_eq("rstmid_latency", 32'(first_edge_at), 32'd7);
        check_eq("rstmid_code", 32'(first_code), 32'd3);

        // Random activity: fast chatter, then slow presses long enough to hold.
        cur = '0;
        for (int k = 0; k < 2500; k++) begin
            for (int b = 0; b < NB; b++) begin
                if (k < 1000) begin
                    if ($urandom_range(0, 3) == 0) cur[b] = ~cur[b];
                end else begin
                    if ($urandom_range(0, 29) == 0) cur[b] = ~cur[b];
                end
            end
            if ($urandom_range(0, 399) == 0) do_reset(cur, $urandom_range(1, 3));
            tick(cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
